id_match_logger: RTL and testbench

- Downstream consumer of the identifier recognizer. Takes the recognizer's per-character match flag and the same character stream.
- Converts each maximal run of match=1 inside a '/'-delimited segment into a record: {start position, run length}.
- Queues records in a small FIFO and offers them on a valid/ready port. Also keeps a wrapping count of all runs and a sticky overflow flag.

---
 rtl/id_pkg.sv | 21 ++
 rtl/id_rec_fifo.sv | 84 ++++++++
 rtl/id_match_logger.sv | 126 ++++++++++++
 tb/tb_id_match_logger.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared types for the identifier match logger.
// Record layout, logger state and small helpers.
package id_pkg;

    localparam logic [7:0] DELIM_SLASH = 8'h2F;

    typedef struct packed {
        logic [7:0] start;
        logic [7:0] len;
    } rec_t;

    typedef enum logic {
        IDLE,
        RUN
    } log_state_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/id_rec_fifo.sv
// Small record FIFO with a registered head output.
// Head is zero whenever the FIFO is empty.
module id_rec_fifo
    import id_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  rec_t i_data,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output logic o_valid,
    output rec_t o_head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    rec_t          r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          r_valid;
    rec_t          r_head;

    logic          w_pop;
    logic          w_push;
    logic [AW-1:0] w_rptr_n;
    logic [CW-1:0] w_cnt_n;
    rec_t          w_head_n;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_pop   = i_pop & r_valid;
    // A pop frees a slot in the same cycle, so full+pop still accepts.
    assign w_push  = i_push & (~o_full | w_pop);

    always_comb begin
        w_rptr_n = r_rptr;
        if (w_pop) begin
            w_rptr_n = r_rptr + AW'(1);
        end
        w_cnt_n  = r_cnt + CW'(w_push) - CW'(w_pop);
        w_head_n = '0;
        if (w_cnt_n != '0) begin
            if (w_push && (r_wptr == w_rptr_n)) begin
                w_head_n = i_data;
            end else begin
                w_head_n = r_mem[w_rptr_n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_head  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            r_rptr  <= w_rptr_n;
            r_cnt   <= w_cnt_n;
            r_valid <= (w_cnt_n != '0);
            r_head  <= w_head_n;
        end
    end

    assign o_valid = r_valid;
    assign o_head  = r_head;

endmodule

// File: rtl/id_match_logger.sv
// Turns runs of recognizer matches into {start,len} records.
// Holds char alignment, segment position, run FSM and counters.
module id_match_logger
    import id_pkg::*;
#(
    parameter int         MATCH_LAT = 1,
    parameter int         DEPTH     = 4,
    parameter logic [7:0] DELIM     = DELIM_SLASH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  char,
    input  logic        match,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [15:0] rec_data,
    output logic [7:0]  run_count,
    output logic        overflow
);

    logic [7:0] w_c;
    logic       w_delim;
    logic       w_hit;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    rec_t       w_head;

    log_state_e r_state;
    log_state_e w_state_n;
    logic [7:0] r_pos;
    logic [7:0] r_start;
    logic [7:0] w_start_n;
    logic [7:0] r_len;
    logic [7:0] w_len_n;
    logic [7:0] r_run_count;
    logic       r_overflow;

    // Re-align char with the lagging match flag.
    if (MATCH_LAT == 0) begin : g_nodly
        assign w_c = char;
    end else begin : g_dly
        logic [7:0] r_dly [MATCH_LAT];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < MATCH_LAT; i++) begin
                    r_dly[i] <= 8'h00;
                end
            end else begin
                r_dly[0] <= char;
                for (int i = 1; i < MATCH_LAT; i++) begin
                    r_dly[i] <= r_dly[i-1];
                end
            end
        end
        assign w_c = r_dly[MATCH_LAT-1];
    end

    assign w_delim = (w_c == DELIM);
    assign w_hit   = match & ~w_delim;
    assign w_pop   = ~w_empty & rec_ready;

    always_comb begin
        w_state_n = r_state;
        w_start_n = r_start;
        w_len_n   = r_len;
        w_push    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_state_n = RUN;
                    w_start_n = r_pos;
                    w_len_n   = 8'd1;
                end
            end
            RUN: begin
                if (w_hit) begin
                    w_len_n = sat_inc(r_len);
                end else begin
                    w_push    = 1'b1;
                    w_state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pos       <= 8'h00;
            r_start     <= 8'h00;
            r_len       <= 8'h00;
            r_run_count <= 8'h00;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_start     <= w_start_n;
            r_len       <= w_len_n;
            r_pos       <= w_delim ? 8'h00 : sat_inc(r_pos);
            r_run_count <= r_run_count + {7'd0, w_push};
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    id_rec_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (rec_t'{start: r_start, len: r_len}),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_valid (rec_valid),
        .o_head  (w_head)
    );

    assign rec_data  = w_head;
    assign run_count = r_run_count;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_id_match_logger.sv
// Bench for id_match_logger: directed cases plus random stream
// against a queue-based reference model.
module tb_id_match_logger;

    localparam int LAT   = 1;
    localparam int DEPTH = 4;
    localparam logic [7:0] SL = 8'h2F;
    localparam logic [7:0] ZC = 8'h7A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  char = 8'h00;
    logic        match = 1'b0;
    logic        rec_valid;
    logic        rec_ready = 1'b0;
    logic [15:0] rec_data;
    logic [7:0]  run_count;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [7:0]  chq [$];
    logic [15:0] fq [$];
    int m_pos, run_pos, run_cyc, cyc, m_rcnt;
    bit in_run, m_ovf;

    // stimulus buffers
    logic [7:0] chs [$];
    bit         ms [$];

    always #5 clk = ~clk;

    id_match_logger #(
        .MATCH_LAT(LAT),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .char      (char),
        .match     (match),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_data  (rec_data),
        .run_count (run_count),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        chq.delete();
        for (int i = 0; i < LAT; i++) chq.push_back(8'h00);
        fq.delete();
        m_pos = 0; run_pos = 0; run_cyc = 0; cyc = 0;
        m_rcnt = 0; in_run = 0; m_ovf = 0;
    endtask

    // One edge of the model, using the inputs presented before the edge.
    task automatic model(input logic [7:0] ch, input bit m, input bit r);
        logic [7:0] c;
        bit pop, push, hit;
        logic [15:0] rec;
        int len;
        pop = (fq.size() > 0) && r;
        chq.push_back(ch);
        c = chq.pop_front();
        hit = m && (c != SL);
        push = 0;
        rec = '0;
        if (hit && !in_run) begin
            in_run = 1; run_pos = m_pos; run_cyc = cyc;
        end else if (!hit && in_run) begin
            in_run = 0; push = 1;
            len = cyc - run_cyc;
            if (len > 255) len = 255;
            rec = {run_pos[7:0], len[7:0]};
        end
        m_pos = (c == SL) ? 0 : ((m_pos < 255) ? m_pos + 1 : 255);
        if (pop) void'(fq.pop_front());
        if (push) begin
            m_rcnt = (m_rcnt + 1) % 256;
            if (fq.size() < DEPTH) fq.push_back(rec);
            else m_ovf = 1;
        end
        cyc++;
    endtask

    task automatic step(input logic [7:0] ch, input bit m, input bit r);
        logic [15:0] eh;
        char = ch; match = m; rec_ready = r;
        @(posedge clk);
        model(ch, m, r);
        #1;
        eh = (fq.size() > 0) ? fq[0] : 16'h0000;
        chk("sb_valid", 32'(rec_valid), 32'(fq.size() > 0));
        chk("sb_data", 32'(rec_data), 32'(eh));
        chk("sb_rcnt", 32'(run_count), 32'(m_rcnt));
        chk("sb_ovf", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic do_reset();
        rst_n = 0; char = 8'h00; match = 0; rec_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        mreset();
    endtask

    task automatic load(input string s, input logic [63:0] mm);
        chs.delete(); ms.delete();
        for (int i = 0; i < s.len(); i++) begin
            chs.push_back(s[i]);
            ms.push_back(mm[i]);
        end
    endtask

    // Drive chs with ms lagged by LAT cycles, as the recognizer would.
    task automatic play(input logic [63:0] rmask);
        int n;
        logic [7:0] ch;
        bit m, r;
        n = chs.size();
        for (int j = 0; j < n + LAT; j++) begin
            ch = (j < n) ? chs[j] : ZC;
            m = (j >= LAT && j - LAT < n) ? ms[j-LAT] : 1'b0;
            r = (j < 64) ? rmask[j] : 1'b0;
            step(ch, m, r);
        end
    endtask

    task automatic drain(input string tag, input logic [15:0] e);
        chk(tag, 32'(rec_data), 32'(e));
        step(ZC, 1'b0, 1'b1);
    endtask

    initial begin
        mreset();
        do_reset();
        chk("rst_valid", 32'(rec_valid), 32'd0);
        chk("rst_data", 32'(rec_data), 32'd0);
        chk("rst_rcnt", 32'(run_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // single run over '1'..'4'
        load("/abcd1234/", 64'h1E0);
        play(64'h0);
        chk("t1_valid", 32'(rec_valid), 32'd1);
        chk("t1_data", 32'(rec_data), 32'h0404);
        chk("t1_rcnt", 32'(run_count), 32'd1);

        // split run
        do_reset();
        load("/abcd1234/", 64'h160);
        play(64'h0);
        chk("t2_rcnt", 32'(run_count), 32'd2);
        drain("t2_rec0", 16'h0402);
        drain("t2_rec1", 16'h0701);
        chk("t2_empty", 32'(rec_valid), 32'd0);

        // overflow: 5 pushes into 4 slots
        do_reset();
        load("/abcdefghij/", 64'h2AA);
        play(64'h0);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_rcnt", 32'(run_count), 32'd5);
        drain("t3_rec0", 16'h0001);
        drain("t3_rec1", 16'h0201);
        drain("t3_rec2", 16'h0401);
        drain("t3_rec3", 16'h0601);
        chk("t3_empty", 32'(rec_valid), 32'd0);

        // full FIFO, push coincides with pop
        do_reset();
        load("/abcdefghij/", 64'h2AA);
        play(64'h1 << (10 + LAT));
        chk("t4_ovf", 32'(overflow), 32'd0);
        chk("t4_rcnt", 32'(run_count), 32'd5);
        drain("t4_rec0", 16'h0201);
        drain("t4_rec1", 16'h0401);
        drain("t4_rec2", 16'h0601);
        drain("t4_rec3", 16'h0801);
        chk("t4_empty", 32'(rec_valid), 32'd0);

        // saturation of len and pos
        do_reset();
        chs.delete(); ms.delete();
        chs.push_back(SL); ms.push_back(0);
        for (int i = 1; i <= 300; i++) begin
            chs.push_back(8'h61);
            ms.push_back((i >= 3 && i <= 280) || i >= 290);
        end
        chs.push_back(SL); ms.push_back(0);
        play(64'h0);
        chk("t5_rcnt", 32'(run_count), 32'd2);
        drain("t5_rec0", 16'h02FF);
        drain("t5_rec1", 16'hFF0B);

        // async reset with a queued record and an open run
        do_reset();
        load("/ab/cdef", 64'hF2);
        play(64'h0);
        chk("t6_pre_valid", 32'(rec_valid), 32'd1);
        chk("t6_pre_rcnt", 32'(run_count), 32'd1);
        #2;
        rst_n = 0;
        #1;
        chk("t6_valid", 32'(rec_valid), 32'd0);
        chk("t6_data", 32'(rec_data), 32'd0);
        chk("t6_rcnt", 32'(run_count), 32'd0);
        chk("t6_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1;
        mreset();
        load("xyz/", 64'h0);
        play(64'h0);
        chk("t6_post", 32'(rec_valid), 32'd0);

        // random stream
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            logic [7:0] ch;
            ch = ($urandom_range(0, 5) == 0) ? SL : 8'(8'h61 + $urandom_range(0, 3));
            step(ch, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
